// File: rtl/cpu_fetch_pkg.sv
// Shared definitions for the fetch controller: defaults, FSM encoding,
// the skid entry layout and the HALT decode helper.
package cpu_fetch_pkg;

    localparam logic [15:0] RESET_PC_DEFAULT    = 16'h0000;
    localparam logic [15:0] PC_INC_DEFAULT      = 16'd2;
    localparam logic [3:0]  HALT_OPCODE_DEFAULT = 4'hF;

    // Bubble encoding presented on inst while nothing has been fetched.
    localparam logic [15:0] NOP_INST = 16'h0000;

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_FULL = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    typedef struct packed {
        logic [15:0] inst;
        logic [15:0] pc;
    } fetch_entry_t;

    function automatic logic is_halt(input logic [15:0] word, input logic [3:0] opcode);
        return word[15:12] == opcode;
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding buffer for an instruction that returned while the
// IF/ID output was stalled and occupied.
module fetch_skid_buf
    import cpu_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         drain,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t dout,
    output logic         full
);

    fetch_entry_t entry_q;
    logic         full_q;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            full_q  <= 1'b0;
            entry_q <= '{inst: NOP_INST, pc: 16'h0000};
        end else if (load) begin
            full_q  <= 1'b1;
            entry_q <= din;
        end else if (drain) begin
            full_q  <= 1'b0;
        end
    end

    assign dout = entry_q;
    assign full = full_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: owns the PC, issues imem reads over req/ack and presents
// fetched instructions (with their PC) to decode.
module fetch_ctrl
    import cpu_fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter logic [15:0] PC_INC      = PC_INC_DEFAULT,
    parameter logic [3:0]  HALT_OPCODE = HALT_OPCODE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_data,
    output logic        inst_valid,
    output logic [15:0] inst,
    output logic [15:0] inst_pc,
    output logic [15:0] inst_pc_plus,
    output logic [15:0] pc,
    output logic        halted,
    output logic [1:0]  fsm_state
);

    // Handshakes: imem_req is held with a stable imem_addr until a one-cycle
    // imem_ack returns the data; an ack with no request raised is ignored.
    // The IF/ID output is taken by decode on any cycle inst_valid=1, stall=0.

    logic [1:0]   state_q;
    logic [15:0]  pc_q;
    logic         req_q;
    logic [15:0]  addr_q;
    logic         kill_q;
    logic         valid_q;
    logic [15:0]  inst_q;
    logic [15:0]  inst_pc_q;
    logic [15:0]  inst_pc_plus_q;
    logic         halted_q;

    logic         ack_ok;
    logic         consume;
    logic         room;
    logic         fetch_ok;
    logic         skid_load;
    logic         skid_drain;
    logic         skid_full;
    logic         ack_halt;
    logic         skid_halt;
    logic [15:0]  pc_next_seq;
    fetch_entry_t fetched;
    fetch_entry_t skid_q;

    always_comb begin
        ack_ok       = imem_ack && req_q;
        consume      = valid_q && !stall;
        room         = !valid_q || !stall;
        fetch_ok     = ack_ok && !kill_q && !redirect && (state_q == S_REQ);
        skid_load    = fetch_ok && !room;
        skid_drain   = (state_q == S_FULL) && skid_full && !stall && !redirect;
        ack_halt     = is_halt(imem_data, HALT_OPCODE);
        skid_halt    = is_halt(skid_q.inst, HALT_OPCODE);
        pc_next_seq  = pc_q + PC_INC;
        fetched.inst = imem_data;
        fetched.pc   = addr_q;
    end

    fetch_skid_buf u_skid (
        .clk   (clk),
        .rst   (rst),
        .load  (skid_load),
        .drain (skid_drain),
        .flush (redirect),
        .din   (fetched),
        .dout  (skid_q),
        .full  (skid_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_REQ;
            pc_q           <= RESET_PC;
            req_q          <= 1'b0;
            addr_q         <= RESET_PC;
            kill_q         <= 1'b0;
            valid_q        <= 1'b0;
            inst_q         <= NOP_INST;
            inst_pc_q      <= 16'h0000;
            inst_pc_plus_q <= PC_INC;
            halted_q       <= 1'b0;
        end else if (redirect) begin
            pc_q     <= redirect_pc;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            state_q  <= S_REQ;
            // Memory cannot abort: keep the old address up and drop its data later.
            if (req_q && !imem_ack) begin
                kill_q <= 1'b1;
            end else begin
                kill_q <= 1'b0;
                req_q  <= 1'b1;
                addr_q <= redirect_pc;
            end
        end else begin
            case (state_q)
                S_REQ: begin
                    if (ack_ok && kill_q) begin
                        kill_q <= 1'b0;
                        addr_q <= pc_q;
                        if (consume) valid_q <= 1'b0;
                    end else if (ack_ok) begin
                        pc_q <= pc_next_seq;
                        if (room) begin
                            valid_q        <= 1'b1;
                            inst_q         <= imem_data;
                            inst_pc_q      <= addr_q;
                            inst_pc_plus_q <= addr_q + PC_INC;
                        end
                        if (ack_halt) begin
                            req_q <= 1'b0;
                            if (room) begin
                                state_q  <= S_HALT;
                                halted_q <= 1'b1;
                            end else begin
                                state_q <= S_FULL;
                            end
                        end else if (room) begin
                            addr_q <= pc_next_seq;
                        end else begin
                            req_q   <= 1'b0;
                            state_q <= S_FULL;
                        end
                    end else begin
                        if (!req_q) begin
                            req_q  <= 1'b1;
                            addr_q <= pc_q;
                        end
                        if (consume) valid_q <= 1'b0;
                    end
                end
                S_FULL: begin
                    if (skid_drain) begin
                        valid_q        <= 1'b1;
                        inst_q         <= skid_q.inst;
                        inst_pc_q      <= skid_q.pc;
                        inst_pc_plus_q <= skid_q.pc + PC_INC;
                        if (skid_halt) begin
                            state_q  <= S_HALT;
                            halted_q <= 1'b1;
                        end else begin
                            state_q <= S_REQ;
                            req_q   <= 1'b1;
                            addr_q  <= pc_q;
                        end
                    end
                end
                S_HALT: begin
                    if (consume) valid_q <= 1'b0;
                end
                default: state_q <= S_REQ;
            endcase
        end
    end

    assign imem_req     = req_q;
    assign imem_addr    = addr_q;
    assign inst_valid   = valid_q;
    assign inst         = inst_q;
    assign inst_pc      = inst_pc_q;
    assign inst_pc_plus = inst_pc_plus_q;
    assign pc           = pc_q;
    assign halted       = halted_q;
    assign fsm_state    = state_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: latency-randomised memory, queue-based
// reference model compared every cycle, plus directed literal checks.
module tb_fetch_ctrl;
    import cpu_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_data = 16'h0000;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        inst_valid;
    logic [15:0] inst;
    logic [15:0] inst_pc;
    logic [15:0] inst_pc_plus;
    logic [15:0] pc;
    logic        halted;
    logic [1:0]  fsm_state;

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_data    (imem_data),
        .inst_valid   (inst_valid),
        .inst         (inst),
        .inst_pc      (inst_pc),
        .inst_pc_plus (inst_pc_plus),
        .pc           (pc),
        .halted       (halted),
        .fsm_state    (fsm_state)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name, input int bound);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event not seen within %0d cycles", name, bound);
    endtask

    // ---------------- memory model ----------------
    logic [15:0] ovr [logic [15:0]];
    bit          halt_rand = 1'b0;
    int          lat_force = 1;
    bit          mem_busy  = 1'b0;
    int          mem_cnt   = 0;
    logic [15:0] mem_addr  = 16'h0000;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        logic [15:0] d;
        if (ovr.exists(a)) return ovr[a];
        d = 16'((32'(a) * 32'd40503) >> 3) ^ 16'h1357;
        if (d[15:12] == 4'hF) d[15:12] = 4'h7;
        if (halt_rand && a[5:1] == 5'd19) d[15:12] = 4'hF;
        return d;
    endfunction

    always @(negedge clk) begin
        imem_ack  = 1'b0;
        imem_data = 16'($urandom);
        if (rst) begin
            mem_busy = 1'b0;
        end else if (mem_busy) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                imem_ack  = 1'b1;
                imem_data = mem_word(mem_addr);
                mem_busy  = 1'b0;
            end
        end else if (imem_req) begin
            mem_busy = 1'b1;
            mem_addr = imem_addr;
            mem_cnt  = (lat_force > 0) ? lat_force : int'($urandom_range(1, 4));
        end
    end

    // ---------------- reference model ----------------
    // exp_q holds {inst, pc} for every instruction fetched but not yet taken
    // by decode: the head is the IF/ID output, a second entry is the held one.
    logic [31:0] exp_q[$];
    logic [15:0] m_pc = 16'h0000;
    logic [15:0] m_addr = 16'h0000;
    bit          m_req = 1'b0;
    bit          m_kill = 1'b0;
    bit          m_halted = 1'b0;
    bit          m_halt_wait = 1'b0;
    bit          model_live = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_pc = 16'h0000; m_addr = 16'h0000;
            m_req = 1'b0; m_kill = 1'b0; m_halted = 1'b0; m_halt_wait = 1'b0;
            model_live = 1'b1;
        end else if (model_live) begin
            if (redirect) begin
                exp_q.delete();
                m_pc = redirect_pc;
                m_halted = 1'b0;
                m_halt_wait = 1'b0;
                if (m_req && !imem_ack) begin
                    m_kill = 1'b1;
                end else begin
                    m_kill = 1'b0; m_req = 1'b1; m_addr = redirect_pc;
                end
            end else begin
                if (exp_q.size() > 0 && !stall) void'(exp_q.pop_front());
                if (imem_ack && m_req) begin
                    if (m_kill) begin
                        m_kill = 1'b0;
                        m_addr = m_pc;
                    end else begin
                        exp_q.push_back({imem_data, m_addr});
                        m_pc = m_pc + 16'd2;
                        if (imem_data[15:12] == 4'hF) begin
                            m_req = 1'b0; m_halt_wait = 1'b1;
                        end else if (exp_q.size() == 2) begin
                            m_req = 1'b0;
                        end else begin
                            m_addr = m_pc;
                        end
                    end
                end else if (!m_req && !m_halt_wait && exp_q.size() < 2) begin
                    m_req = 1'b1;
                    m_addr = m_pc;
                end
                if (m_halt_wait && exp_q.size() < 2) m_halted = 1'b1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic [31:0] head;
        logic [1:0]  exp_state;
        if (model_live) begin
            chk("model_inst_valid", 16'(inst_valid), 16'(exp_q.size() > 0));
            if (exp_q.size() > 0) begin
                head = exp_q[0];
                chk("model_inst", inst, head[31:16]);
                chk("model_inst_pc", inst_pc, head[15:0]);
                chk("model_inst_pc_plus", inst_pc_plus, head[15:0] + 16'd2);
            end
            chk("model_imem_req", 16'(imem_req), 16'(m_req));
            chk("model_imem_addr", imem_addr, m_addr);
            chk("model_pc", pc, m_pc);
            chk("model_halted", 16'(halted), 16'(m_halted));
            exp_state = m_halted ? S_HALT : (exp_q.size() == 2 ? S_FULL : S_REQ);
            chk("model_fsm_state", 16'(fsm_state), 16'(exp_state));
        end
    end

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_consume(input string name, input int bound,
                                output logic [15:0] ipc, output logic [15:0] iword,
                                output logic [15:0] iplus);
        bit got = 1'b0;
        ipc = 16'h0; iword = 16'h0; iplus = 16'h0;
        for (int i = 0; i < bound && !got; i++) begin
            if (inst_valid && !stall) begin
                got = 1'b1;
                ipc = inst_pc; iword = inst; iplus = inst_pc_plus;
            end
            tick();
        end
        if (!got) timeout(name, bound);
    endtask

    task automatic reset_dut();
        rst = 1'b1; stall = 1'b0; redirect = 1'b0;
        tick(); tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ipc, iword, iplus;
        bit          seen;

        // Reset values, then sequential fetch with ack latency 1.
        lat_force = 1;
        tick(); tick();
        chk("lit_rst_inst_valid", 16'(inst_valid), 16'h0);
        chk("lit_rst_inst", inst, 16'h0000);
        chk("lit_rst_inst_pc", inst_pc, 16'h0000);
        chk("lit_rst_inst_pc_plus", inst_pc_plus, 16'h0002);
        chk("lit_rst_pc", pc, 16'h0000);
        chk("lit_rst_imem_req", 16'(imem_req), 16'h0);
        chk("lit_rst_imem_addr", imem_addr, 16'h0000);
        chk("lit_rst_halted", 16'(halted), 16'h0);
        rst = 1'b0;
        tick();
        chk("lit_first_req", 16'(imem_req), 16'h1);
        chk("lit_first_addr", imem_addr, 16'h0000);
        for (int k = 0; k < 3; k++) begin
            wait_consume("seq_consume", 20, ipc, iword, iplus);
            chk("lit_seq_pc", ipc, 16'(2 * k));
            chk("lit_seq_plus", iplus, 16'(2 * k + 2));
        end

        // Stall while the second instruction returns: skid fills, order kept.
        reset_dut();
        ovr[16'h0000] = 16'hABCD;
        ovr[16'h0002] = 16'h1234;
        stall = 1'b1;
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            tick();
            if (inst_valid && !imem_req) seen = 1'b1;
        end
        if (!seen) timeout("skid_fill", 30);
        tick(); tick(); tick();
        chk("lit_skid_req_low", 16'(imem_req), 16'h0);
        chk("lit_skid_out_inst", inst, 16'hABCD);
        chk("lit_skid_out_valid", 16'(inst_valid), 16'h1);
        stall = 1'b0;
        wait_consume("skid_first", 10, ipc, iword, iplus);
        chk("lit_skid_first_inst", iword, 16'hABCD);
        chk("lit_skid_first_pc", ipc, 16'h0000);
        wait_consume("skid_second", 10, ipc, iword, iplus);
        chk("lit_skid_second_inst", iword, 16'h1234);
        chk("lit_skid_second_pc", ipc, 16'h0002);
        wait_consume("skid_third", 10, ipc, iword, iplus);
        chk("lit_skid_third_pc", ipc, 16'h0004);

        // Redirect while the 0x0006 request is outstanding (ack 3 cycles later).
        reset_dut();
        ovr.delete();
        lat_force = 3;
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            tick();
            if (imem_req && imem_addr == 16'h0006 && !imem_ack) seen = 1'b1;
        end
        if (!seen) timeout("kill_setup", 60);
        redirect = 1'b1; redirect_pc = 16'h0040;
        tick();
        redirect = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            chk("lit_kill_addr_held", imem_addr, 16'h0006);
            chk("lit_kill_no_valid", 16'(inst_valid), 16'h0);
            if (imem_ack) seen = 1'b1;
            tick();
        end
        if (!seen) timeout("kill_ack", 10);
        chk("lit_kill_new_addr", imem_addr, 16'h0040);
        chk("lit_kill_new_req", 16'(imem_req), 16'h1);
        chk("lit_kill_valid_after", 16'(inst_valid), 16'h0);
        wait_consume("kill_resume", 20, ipc, iword, iplus);
        chk("lit_kill_resume_pc", ipc, 16'h0040);

        // Redirect coincident with an ack.
        lat_force = 2;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (imem_ack) seen = 1'b1;
            else tick();
        end
        if (!seen) timeout("coinc_ack", 20);
        redirect = 1'b1; redirect_pc = 16'h0100;
        tick();
        redirect = 1'b0;
        chk("lit_coinc_addr", imem_addr, 16'h0100);
        chk("lit_coinc_req", 16'(imem_req), 16'h1);
        chk("lit_coinc_valid", 16'(inst_valid), 16'h0);
        wait_consume("coinc_resume", 20, ipc, iword, iplus);
        chk("lit_coinc_resume_pc", ipc, 16'h0100);
        chk("lit_coinc_resume_inst", iword, mem_word(16'h0100));

        // HALT at 0x0010, then redirect out of it.
        reset_dut();
        ovr[16'h0010] = 16'hF000;
        lat_force = 0;
        rst = 1'b0;
        for (int k = 0; k < 9; k++) wait_consume("halt_walk", 40, ipc, iword, iplus);
        chk("lit_halt_pc", ipc, 16'h0010);
        chk("lit_halt_inst", iword, 16'hF000);
        tick(); tick(); tick(); tick();
        chk("lit_halt_halted", 16'(halted), 16'h1);
        chk("lit_halt_req", 16'(imem_req), 16'h0);
        chk("lit_halt_next_pc", pc, 16'h0012);
        chk("lit_halt_valid", 16'(inst_valid), 16'h0);
        redirect = 1'b1; redirect_pc = 16'h0020;
        tick();
        redirect = 1'b0;
        chk("lit_unhalt_halted", 16'(halted), 16'h0);
        chk("lit_unhalt_req", 16'(imem_req), 16'h1);
        chk("lit_unhalt_addr", imem_addr, 16'h0020);
        wait_consume("unhalt_resume", 20, ipc, iword, iplus);
        chk("lit_unhalt_resume_pc", ipc, 16'h0020);

        // Wrap from 0xFFFE to 0x0000.
        redirect = 1'b1; redirect_pc = 16'hFFFE;
        tick();
        redirect = 1'b0;
        wait_consume("wrap_first", 20, ipc, iword, iplus);
        chk("lit_wrap_pc", ipc, 16'hFFFE);
        chk("lit_wrap_plus", iplus, 16'h0000);
        wait_consume("wrap_second", 20, ipc, iword, iplus);
        chk("lit_wrap_next_pc", ipc, 16'h0000);

        // Randomised traffic against the model.
        reset_dut();
        ovr.delete();
        halt_rand = 1'b1;
        lat_force = 0;
        rst = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            stall       = ($urandom_range(0, 9) < 3);
            redirect    = ($urandom_range(0, 99) < 4);
            redirect_pc = 16'($urandom) & 16'hFFFE;
            rst         = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 1'b0; stall = 1'b0; redirect = 1'b0;
        tick(); tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
